// File: rtl/spi_req_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: FSM state encoding,
// command layout defaults and width helpers.
package spi_ctrl_pkg;

    // Controller states, 3-bit encoding kept stable for existing tooling.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GRANT = 3'd1;
    localparam logic [2:0] BUSY  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    // Default command layout: bit 11 set means a 12-bit write shift-out,
    // clear means a 4-bit address followed by an 8-bit read.
    localparam int CMD_WR_BIT         = 11;
    localparam int DEF_CMD_WIDTH      = 12;
    localparam int DEF_READ_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Width of the timeout counter; it only ever holds 0 .. cycles-1.
    function automatic int tmo_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a requester index; a single bit minimum so ports never vanish.
    function automatic int id_width(input int num_req);
        int w;
        w = $clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// environment (requesters plus SPI master) that drives the arbiter.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]           req_vld;
    logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
    logic [NUM_REQ-1:0]           req_rdy;
    logic                         rsp_vld;
    logic [ID_W-1:0]              rsp_id;
    logic                         rsp_wr;
    logic [READ_WIDTH-1:0]        rsp_data;
    logic                         rsp_err;

    // SPI master side
    logic [CMD_WIDTH-1:0]         spi_cmd_in;
    logic                         spi_cmd_vld;
    logic                         spi_cmd_rdy;
    logic                         spi_read_vld;
    logic [READ_WIDTH-1:0]        spi_read_data;

    modport slave (
        input  req_vld, req_cmd, spi_cmd_rdy, spi_read_vld, spi_read_data,
        output req_rdy, rsp_vld, rsp_id, rsp_wr, rsp_data, rsp_err,
               spi_cmd_in, spi_cmd_vld
    );

    modport master (
        output req_vld, req_cmd, spi_cmd_rdy, spi_read_vld, spi_read_data,
        input  req_rdy, rsp_vld, rsp_id, rsp_wr, rsp_data, rsp_err,
               spi_cmd_in, spi_cmd_vld
    );

endinterface

// File: rtl/spi_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int  cand;
    logic found;

    // Scan NUM_REQ slots starting at ptr and keep the first active one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master command port between NUM_REQ requesters.
// Round-robin accept in IDLE, present the command in GRANT, follow the
// SPI master through BUSY/DONE, then return a one-cycle tagged response.
// A per-transaction cycle budget aborts hung transfers with an error.
module spi_req_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int CMD_WIDTH      = DEF_CMD_WIDTH,
    parameter int READ_WIDTH     = DEF_READ_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_req_arbiter_if.slave  bus
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam int TW   = tmo_cnt_width(TIMEOUT_CYCLES);

    // Controller state and transaction context
    logic [2:0]            state;
    logic [ID_W-1:0]       ptr;
    logic [TW-1:0]         tmo_cnt;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [ID_W-1:0]       id_q;
    logic                  wr_q;
    logic                  read_seen;

    // Registered outputs
    logic                  spi_cmd_vld_q;
    logic                  rsp_vld_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic                  rsp_wr_q;
    logic [READ_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

    // Arbitration results
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       win_idx;
    logic [CMD_WIDTH-1:0]  win_cmd;
    logic [ID_W-1:0]       ptr_nxt;
    logic                  any_req;
    logic                  tmo_hit;
    logic                  read_seen_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (bus.req_vld),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign any_req       = |bus.req_vld;
    assign win_cmd       = bus.req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];
    assign ptr_nxt       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign tmo_hit       = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign read_seen_nxt = read_seen | bus.spi_read_vld;

    // The accept strobe is the only combinational output; it is gated to
    // IDLE so a requester is never acknowledged while a transfer is open.
    assign bus.req_rdy     = (state == IDLE) ? gnt : '0;

    assign bus.spi_cmd_in  = cmd_q;
    assign bus.spi_cmd_vld = spi_cmd_vld_q;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_wr      = rsp_wr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;

    // Transaction FSM: accept, hand over to SPI, track completion, respond.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            tmo_cnt       <= '0;
            cmd_q         <= '0;
            id_q          <= '0;
            wr_q          <= 1'b0;
            read_seen     <= 1'b0;
            spi_cmd_vld_q <= 1'b0;
            rsp_vld_q     <= 1'b0;
            rsp_id_q      <= '0;
            rsp_wr_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            // The response strobe is only ever raised for a single cycle.
            rsp_vld_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        cmd_q         <= win_cmd;
                        id_q          <= win_idx;
                        wr_q          <= win_cmd[CMD_WIDTH-1];
                        ptr           <= ptr_nxt;
                        tmo_cnt       <= '0;
                        read_seen     <= 1'b0;
                        spi_cmd_vld_q <= 1'b1;
                        state         <= GRANT;
                    end
                end

                GRANT, BUSY, DONE: begin
                    if (tmo_hit) begin
                        // Budget exhausted: abandon the transfer and report.
                        spi_cmd_vld_q <= 1'b0;
                        rsp_vld_q     <= 1'b1;
                        rsp_id_q      <= id_q;
                        rsp_wr_q      <= wr_q;
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == GRANT) begin
                            if (bus.spi_cmd_rdy) begin
                                spi_cmd_vld_q <= 1'b0;
                                state         <= BUSY;
                            end
                        end else if (state == BUSY) begin
                            // Ready still high here means the master never
                            // started; keep waiting and let the budget expire.
                            if (!bus.spi_cmd_rdy) begin
                                state <= DONE;
                            end
                        end else begin
                            read_seen <= read_seen_nxt;
                            if (bus.spi_cmd_rdy) begin
                                rsp_vld_q  <= 1'b1;
                                rsp_id_q   <= id_q;
                                rsp_wr_q   <= wr_q;
                                rsp_data_q <= (!wr_q && read_seen_nxt) ?
                                              bus.spi_read_data : '0;
                                rsp_err_q  <= !wr_q && !read_seen_nxt;
                                state      <= RESP;
                            end
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one SPI master command port between NUM_REQ requesters using round-robin arbitration.
- Accepts a 12-bit command from the granted requester and presents it to the SPI master with a valid/ready handshake.
- Tracks the transaction to completion and returns a one-cycle response (read data, write acknowledge or timeout error) tagged with the requester id.
- Sits between bus-side agents and the SPI master. Command bit 11 set = write (12-bit shift-out); bit 11 clear = read (4-bit address, then 8-bit read).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CMD_WIDTH, 12, command width; bit CMD_WIDTH-1 is the write flag.
- READ_WIDTH, 8, read data width.
- TIMEOUT_CYCLES, 4096, maximum clk cycles from GRANT entry to completion before the arbiter aborts.
- ID_W (localparam), max(1, clog2(NUM_REQ)), width of the requester id.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low.
- req_vld  in  NUM_REQ  per-requester command valid; held until accepted.
- req_cmd  in  NUM_REQ*CMD_WIDTH  flattened commands; requester i occupies bits [i*CMD_WIDTH +: CMD_WIDTH].
- req_rdy  out  NUM_REQ  one-hot accept strobe.
- rsp_vld  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_wr  out  1  1 = write acknowledge, 0 = read response.
- rsp_data  out  READ_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  timeout, or read finished without spi_read_vld.
- spi_cmd_in  out  CMD_WIDTH  command to the SPI master.
- spi_cmd_vld  out  1  command valid to the SPI master.
- spi_cmd_rdy  in  1  SPI master idle/ready; low while a transfer is in progress.
- spi_read_vld  in  1  SPI read phase active.
- spi_read_data  in  READ_WIDTH  SPI read shift data.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0; round-robin pointer 0; timeout counter 0; latched cmd, id and data 0. Reset mid-transfer aborts with no response; the SPI master is reset by the same rst_n.
- req_rdy is combinational: req_rdy[g] = (state==IDLE) & req_vld[g], where g is the round-robin winner. At most one bit is ever set, and req_rdy is 0 outside IDLE.
- Round-robin: the search starts at pointer and wraps modulo NUM_REQ. On an accept of g, pointer <= (g+1) mod NUM_REQ. Requests that arrive while busy wait, with no loss and no reordering within a requester.
- States:
  - IDLE: on any req_vld, latch req_cmd[g], g and wr flag; -> GRANT next cycle.
  - GRANT: spi_cmd_vld=1, spi_cmd_in=latched cmd. If spi_cmd_vld & spi_cmd_rdy at the edge -> BUSY, and spi_cmd_vld drops on that edge.
  - BUSY: wait for spi_cmd_rdy==0 -> DONE.
  - DONE: set the read_seen flag if spi_read_vld==1. When spi_cmd_rdy==1, capture spi_read_data if the command is a read -> RESP.
  - RESP: rsp_vld=1 for exactly one cycle with rsp_id, rsp_wr, rsp_data and rsp_err; -> IDLE.
- Error on a missing read phase: a read that reaches RESP with read_seen==0 gives rsp_err=1 and rsp_data=0.
- Timeout: the counter clears on GRANT entry and increments in GRANT, BUSY and DONE. When it reaches TIMEOUT_CYCLES-1: -> RESP with rsp_err=1, rsp_data=0, spi_cmd_vld=0.
- Latency: accept edge to first spi_cmd_vld = 1 cycle. SPI completion (spi_cmd_rdy rising in DONE) to rsp_vld = 1 cycle. Minimum turnaround from RESP to the next accept = 1 cycle (IDLE).
- All outputs except req_rdy are registered. spi_cmd_in is stable throughout GRANT.
- spi_cmd_rdy high in BUSY (SPI never went busy) is not a completion: keep waiting; the timeout covers it.

Decomposition:
- Package spi_ctrl_pkg:
  - state localparams IDLE/GRANT/BUSY/DONE/RESP (3-bit encoding);
  - CMD_WR_BIT = 11;
  - default CMD_WIDTH and READ_WIDTH;
  - timeout counter width function.
- Sub-module rr_arbiter:
  - inputs: NUM_REQ request vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational. The pointer register stays in spi_req_arbiter.

Test Plan:
- Single write: req_vld[0]=1, req_cmd[0]=12'h8A5. Expect req_rdy[0] pulse; spi_cmd_in=12'h8A5 with spi_cmd_vld until accepted. After spi_cmd_rdy goes low then high, expect rsp_vld=1, rsp_id=0, rsp_wr=1, rsp_err=0, rsp_data=0.
- Single read: req_cmd[1]=12'h030; SPI model drives spi_read_vld and returns 8'h5C. Expect rsp_vld with rsp_id=1, rsp_wr=0, rsp_data=8'h5C, rsp_err=0.
- Round-robin: both req_vld held with 3 commands each, starting from reset (pointer 0). Expect grant order 0,1,0,1,0,1, no starvation, and req_rdy never asserted during BUSY or DONE.
- Timeout: TIMEOUT_CYCLES=16; SPI model holds spi_cmd_rdy=0 forever after accept. Expect rsp_vld with rsp_err=1 and rsp_data=0 exactly at count 15. Then IDLE, and the next request is accepted.
- Missing read phase: read command, and SPI completes without ever asserting spi_read_vld. Expect rsp_err=1 and rsp_data=0.
- Reset mid-transfer: assert rst_n=0 for one edge during DONE. Expect all outputs 0 on the next cycle, no rsp_vld, and the pointer back at 0 (requester 0 wins next).
